// File: rtl/div_reservation_station.sv
// Reservation station for the FP divide unit: holds ops until operands arrive via the CDB and
// dispatches the lowest-index ready op. Optional `DIVRS_CDB_BYPASS_EN enables same-cycle CDB bypass.
module div_reservation_station #(
  parameter int unsigned ENTRIES  = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned BASE_TAG = 4,
  parameter int unsigned OP_W     = 2
) (
  input  logic              clk,
  input  logic              nRST,
  // issue side
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  // common data bus
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  // divider side
  input  logic              alu_available,
  output logic              alu_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [TAG_W-1:0]  alu_tag,
  output logic [2:0]        busy_cnt
);

  localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q [ENTRIES];
  logic [OP_W-1:0]    op_d [ENTRIES];
  logic [DATA_W-1:0]  vj_q [ENTRIES];
  logic [DATA_W-1:0]  vj_d [ENTRIES];
  logic [DATA_W-1:0]  vk_q [ENTRIES];
  logic [DATA_W-1:0]  vk_d [ENTRIES];
  logic [TAG_W-1:0]   qj_q [ENTRIES];
  logic [TAG_W-1:0]   qj_d [ENTRIES];
  logic [TAG_W-1:0]   qk_q [ENTRIES];
  logic [TAG_W-1:0]   qk_d [ENTRIES];

  logic               cdb_live;
  logic [ENTRIES-1:0] hit_j, hit_k, ready;
  logic [IdxW-1:0]    free_idx, disp_idx;
  logic               any_free, any_ready, issue_fire;
  logic [DATA_W-1:0]  new_vj, new_vk;
  logic [TAG_W-1:0]   new_qj, new_qk;

  // Tag 0 means "no producer", so a tag-0 broadcast must never match anything.
  always_comb begin
    cdb_live = cdb_valid && (cdb_tag != '0);
    for (int i = 0; i < int'(ENTRIES); i++) begin
      hit_j[i] = cdb_live && busy_q[i] && (qj_q[i] == cdb_tag);
      hit_k[i] = cdb_live && busy_q[i] && (qk_q[i] == cdb_tag);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
`ifdef DIVRS_CDB_BYPASS_EN
      ready[i] = busy_q[i] && ((qj_q[i] == '0) || hit_j[i]) && ((qk_q[i] == '0) || hit_k[i]);
`else
      ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
`endif
    end
  end

  // Descending scan leaves the lowest matching index in each selector.
  always_comb begin
    free_idx = '0;
    disp_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IdxW'(i);
      if (ready[i])   disp_idx = IdxW'(i);
    end
    any_free  = ~&busy_q;
    any_ready = |ready;
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      busy_cnt = busy_cnt + 3'(busy_q[i]);
    end
  end

  always_comb begin
    issue_ready = any_free;
    issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(free_idx);
    issue_fire  = issue_valid && any_free;
  end

  always_comb begin
    alu_en  = alu_available && any_ready;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    alu_tag = '0;
    if (alu_en) begin
      alu_a   = vj_q[disp_idx];
      alu_b   = vk_q[disp_idx];
      alu_op  = op_q[disp_idx];
      alu_tag = TAG_W'(BASE_TAG) + TAG_W'(disp_idx);
`ifdef DIVRS_CDB_BYPASS_EN
      if (hit_j[disp_idx]) alu_a = cdb_data;
      if (hit_k[disp_idx]) alu_b = cdb_data;
`endif
    end
  end

  // An operand whose producer broadcasts in the issue cycle is captured on the way in.
  always_comb begin
    new_vj = issue_vj;
    new_qj = issue_qj;
    new_vk = issue_vk;
    new_qk = issue_qk;
    if (cdb_live && (issue_qj == cdb_tag)) begin
      new_vj = cdb_data;
      new_qj = '0;
    end
    if (cdb_live && (issue_qk == cdb_tag)) begin
      new_vk = cdb_data;
      new_qk = '0;
    end
  end

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (hit_j[i]) begin
        vj_d[i] = cdb_data;
        qj_d[i] = '0;
      end
      if (hit_k[i]) begin
        vk_d[i] = cdb_data;
        qk_d[i] = '0;
      end
      if (alu_en && (disp_idx == IdxW'(i))) busy_d[i] = 1'b0;
      // The free slot is never the dispatching one, so issue and dispatch cannot collide.
      if (issue_fire && (free_idx == IdxW'(i))) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op;
        vj_d[i]   = new_vj;
        qj_d[i]   = new_qj;
        vk_d[i]   = new_vk;
        qk_d[i]   = new_qk;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      vj_q   <= vj_d;
      vk_q   <= vk_d;
      qj_q   <= qj_d;
      qk_q   <= qk_d;
    end
  end

endmodule

// File: tb/tb_div_reservation_station.sv
// Bench for div_reservation_station: directed scenarios plus randomized traffic checked against
// a slot-level behavioural model of the station.
module tb_div_reservation_station;

  logic        clk = 1'b0;
  logic        nRST;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [3:0]  issue_qj, issue_qk;
  logic        issue_ready;
  logic [3:0]  issue_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        alu_available;
  logic        alu_en;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [3:0]  alu_tag;
  logic [2:0]  busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  div_reservation_station #(
    .ENTRIES(3), .DATA_W(32), .TAG_W(4), .BASE_TAG(4), .OP_W(2)
  ) dut (
    .clk(clk), .nRST(nRST),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_vk(issue_vk), .issue_qk(issue_qk),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_available(alu_available), .alu_en(alu_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_tag(alu_tag),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: a list of slots, each either holding an op or empty.
  typedef struct {
    bit          busy;
    logic [1:0]  op;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk;
  } slot_t;

  slot_t       m [3];
  bit          e_ready, e_en;
  int          e_free, e_sel, e_cnt;
  logic [31:0] e_a, e_b;
  logic [1:0]  e_op;
  logic [3:0]  e_itag, e_atag;

  function automatic bit on_bus(logic [3:0] q);
    return cdb_valid && (cdb_tag != 4'd0) && (q == cdb_tag);
  endfunction

  function automatic bit operand_ok(logic [3:0] q);
`ifdef DIVRS_CDB_BYPASS_EN
    return (q == 4'd0) || on_bus(q);
`else
    return q == 4'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m[i].busy = 0; m[i].op = 0; m[i].vj = 0; m[i].vk = 0; m[i].qj = 0; m[i].qk = 0;
    end
  endtask

  task automatic model_eval();
    e_cnt = 0; e_free = -1; e_sel = -1;
    for (int i = 2; i >= 0; i--) begin
      if (m[i].busy) e_cnt++;
      else e_free = i;
      if (m[i].busy && operand_ok(m[i].qj) && operand_ok(m[i].qk)) e_sel = i;
    end
    e_ready = (e_free >= 0);
    e_itag  = e_ready ? 4'(4 + e_free) : 4'd0;
    e_en    = alu_available && (e_sel >= 0);
    e_a = 0; e_b = 0; e_op = 0; e_atag = 0;
    if (e_en) begin
      e_a    = (m[e_sel].qj != 0) ? cdb_data : m[e_sel].vj;
      e_b    = (m[e_sel].qk != 0) ? cdb_data : m[e_sel].vk;
      e_op   = m[e_sel].op;
      e_atag = 4'(4 + e_sel);
    end
  endtask

  task automatic model_step();
    slot_t n [3];
    model_eval();
    n = m;
    if (e_en) n[e_sel].busy = 0;
    for (int i = 0; i < 3; i++) begin
      if (m[i].busy && on_bus(m[i].qj)) begin n[i].vj = cdb_data; n[i].qj = 0; end
      if (m[i].busy && on_bus(m[i].qk)) begin n[i].vk = cdb_data; n[i].qk = 0; end
    end
    if (issue_valid && e_ready) begin
      n[e_free].busy = 1;
      n[e_free].op   = issue_op;
      n[e_free].vj   = on_bus(issue_qj) ? cdb_data : issue_vj;
      n[e_free].qj   = on_bus(issue_qj) ? 4'd0 : issue_qj;
      n[e_free].vk   = on_bus(issue_qk) ? cdb_data : issue_vk;
      n[e_free].qk   = on_bus(issue_qk) ? 4'd0 : issue_qk;
    end
    m = n;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_op = 0; issue_vj = 0; issue_qj = 0; issue_vk = 0; issue_qk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic drive_issue(input logic [1:0] op, input logic [31:0] vj, input logic [3:0] qj,
                             input logic [31:0] vk, input logic [3:0] qk);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
  endtask

  task automatic apply_reset();
    idle_inputs();
    alu_available = 0;
    nRST = 0;
    @(posedge clk);
    @(negedge clk);
    nRST = 1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (busy_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", busy_cnt); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b exp 1", issue_ready); end
    n_cmp++; if (issue_tag !== 4'd4) begin n_err++; $display("FAIL reset_itag got %0d exp 4", issue_tag); end
    n_cmp++; if (alu_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %0b exp 0", alu_en); end
    n_cmp++;
    if ({alu_a, alu_b, alu_op, alu_tag} !== 70'd0) begin
      n_err++; $display("FAIL reset_alu got a=%0h b=%0h op=%0d tag=%0d exp all 0", alu_a, alu_b, alu_op, alu_tag);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    alu_available = 1;
    drive_issue(2'd1, 32'd6, 4'd0, 32'd3, 4'd0);
    #1; step();
    idle_inputs(); #1;
    n_cmp++; if (alu_en !== 1'b1) begin n_err++; $display("FAIL basic_en got %0b exp 1", alu_en); end
    n_cmp++; if (alu_a !== 32'd6 || alu_b !== 32'd3) begin n_err++; $display("FAIL basic_ab got %0d/%0d exp 6/3", alu_a, alu_b); end
    n_cmp++; if (alu_tag !== 4'd4 || alu_op !== 2'd1) begin n_err++; $display("FAIL basic_tag got tag=%0d op=%0d exp 4/1", alu_tag, alu_op); end
    n_cmp++; if (busy_cnt !== 3'd1) begin n_err++; $display("FAIL basic_cnt1 got %0d exp 1", busy_cnt); end
    step(); #1;
    n_cmp++; if (busy_cnt !== 3'd0 || alu_en !== 1'b0) begin n_err++; $display("FAIL basic_drain got cnt=%0d en=%0b exp 0/0", busy_cnt, alu_en); end
  endtask

  task automatic test_wakeup();
    apply_reset();
    alu_available = 1;
    drive_issue(2'd2, 32'd0, 4'd9, 32'd2, 4'd0);
    #1; step();
    idle_inputs(); #1;
    n_cmp++; if (alu_en !== 1'b0) begin n_err++; $display("FAIL wake_wait got %0b exp 0", alu_en); end
    step();
    cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 32'd8; #1;
`ifdef DIVRS_CDB_BYPASS_EN
    n_cmp++; if (alu_en !== 1'b1 || alu_a !== 32'd8 || alu_b !== 32'd2) begin
      n_err++; $display("FAIL wake_bypass got en=%0b a=%0d b=%0d exp 1/8/2", alu_en, alu_a, alu_b);
    end
    step(); idle_inputs(); #1;
    n_cmp++; if (busy_cnt !== 3'd0) begin n_err++; $display("FAIL wake_cnt got %0d exp 0", busy_cnt); end
`else
    n_cmp++; if (alu_en !== 1'b0) begin n_err++; $display("FAIL wake_bcast got %0b exp 0", alu_en); end
    step(); idle_inputs(); #1;
    n_cmp++; if (alu_en !== 1'b1 || alu_a !== 32'd8 || alu_b !== 32'd2) begin
      n_err++; $display("FAIL wake_disp got en=%0b a=%0d b=%0d exp 1/8/2", alu_en, alu_a, alu_b);
    end
`endif
    step();
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(2'(i), 32'(10 + i), 4'd0, 32'(20 + i), 4'd0);
      #1; step();
    end
    idle_inputs(); #1;
    n_cmp++; if (busy_cnt !== 3'd3 || issue_ready !== 1'b0) begin
      n_err++; $display("FAIL full_state got cnt=%0d ready=%0b exp 3/0", busy_cnt, issue_ready);
    end
    drive_issue(2'd3, 32'd99, 4'd0, 32'd99, 4'd0);
    #1; step();
    idle_inputs(); alu_available = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (alu_en !== 1'b1 || alu_tag !== 4'(4 + i) || alu_a !== 32'(10 + i)) begin
        n_err++; $display("FAIL full_order%0d got en=%0b tag=%0d a=%0d exp 1/%0d/%0d", i, alu_en, alu_tag, alu_a, 4 + i, 10 + i);
      end
      step();
    end
    #1;
    n_cmp++; if (busy_cnt !== 3'd0) begin n_err++; $display("FAIL full_drain got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_issue_wakeup();
    apply_reset();
    alu_available = 1;
    drive_issue(2'd0, 32'd0, 4'd7, 32'd1, 4'd0);
    cdb_valid = 1; cdb_tag = 4'd7; cdb_data = 32'd21;
    #1; step();
    idle_inputs(); #1;
    n_cmp++; if (alu_en !== 1'b1 || alu_a !== 32'd21 || alu_b !== 32'd1) begin
      n_err++; $display("FAIL issue_wake got en=%0b a=%0d b=%0d exp 1/21/1", alu_en, alu_a, alu_b);
    end
    step();
  endtask

  task automatic test_full_dispatch();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(2'd1, 32'(30 + i), 4'd0, 32'd5, 4'd0);
      #1; step();
    end
    alu_available = 1;
    drive_issue(2'd2, 32'd77, 4'd0, 32'd7, 4'd0);
    #1;
    n_cmp++; if (issue_ready !== 1'b0 || alu_en !== 1'b1 || alu_tag !== 4'd4) begin
      n_err++; $display("FAIL fd_same got ready=%0b en=%0b tag=%0d exp 0/1/4", issue_ready, alu_en, alu_tag);
    end
    step();
    idle_inputs(); alu_available = 0; #1;
    n_cmp++; if (issue_ready !== 1'b1 || issue_tag !== 4'd4 || busy_cnt !== 3'd2) begin
      n_err++; $display("FAIL fd_next got ready=%0b itag=%0d cnt=%0d exp 1/4/2", issue_ready, issue_tag, busy_cnt);
    end
    alu_available = 1;
    #1; step(); step(); #1;
    n_cmp++; if (busy_cnt !== 3'd0) begin n_err++; $display("FAIL fd_drain got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive_issue(2'd3, 32'(40 + i), 4'd0, 32'd4, 4'd0);
      #1; step();
    end
    idle_inputs(); alu_available = 1; #1;
    n_cmp++; if (alu_en !== 1'b1 || busy_cnt !== 3'd2) begin
      n_err++; $display("FAIL mid_pre got en=%0b cnt=%0d exp 1/2", alu_en, busy_cnt);
    end
    nRST = 0; #1;
    n_cmp++; if (alu_en !== 1'b0 || busy_cnt !== 3'd0) begin
      n_err++; $display("FAIL mid_rst got en=%0b cnt=%0d exp 0/0", alu_en, busy_cnt);
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    nRST = 1;
    for (int t = 4; t <= 5; t++) begin
      cdb_valid = 1; cdb_tag = 4'(t); cdb_data = 32'hdead;
      #1;
      n_cmp++; if (alu_en !== 1'b0) begin n_err++; $display("FAIL mid_tag%0d got en=%0b exp 0", t, alu_en); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      issue_valid   = ($urandom_range(0, 99) < 50);
      issue_op      = 2'($urandom);
      issue_vj      = $urandom;
      issue_vk      = $urandom;
      issue_qj      = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
      issue_qk      = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
      cdb_valid     = ($urandom_range(0, 99) < 60);
      cdb_tag       = 4'($urandom_range(0, 9));
      cdb_data      = $urandom;
      alu_available = ($urandom_range(0, 99) < 60);
      #1;
      model_eval();
      n_cmp++; if (issue_ready !== e_ready || busy_cnt !== 3'(e_cnt)) begin
        n_err++; $display("FAIL rnd_occ c=%0d got ready=%0b cnt=%0d exp %0b/%0d", c, issue_ready, busy_cnt, e_ready, e_cnt);
      end
      if (e_ready) begin
        n_cmp++; if (issue_tag !== e_itag) begin
          n_err++; $display("FAIL rnd_itag c=%0d got %0d exp %0d", c, issue_tag, e_itag);
        end
      end
      n_cmp++;
      if (alu_en !== e_en || alu_a !== e_a || alu_b !== e_b || alu_op !== e_op || alu_tag !== e_atag) begin
        n_err++;
        $display("FAIL rnd_alu c=%0d got en=%0b a=%0h b=%0h op=%0d tag=%0d exp en=%0b a=%0h b=%0h op=%0d tag=%0d",
                 c, alu_en, alu_a, alu_b, alu_op, alu_tag, e_en, e_a, e_b, e_op, e_atag);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    nRST = 0;
    alu_available = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_issue_wakeup();
    test_full_dispatch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
